// File: rtl/dircc_stream_arbiter_pkg.sv
// Shared types and helpers for the DiRCC packet-atomic stream arbiter.
// Optional statistics counters are enabled with the DIRCC_ARB_STATS_EN macro.
package dircc_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Channel-field width: ceil(log2(n)), but at least one bit so a 1-channel index still exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dircc_stream_arbiter_if.sv
// Avalon-ST bundle for the arbiter: N_CH input streams merged into one channel-tagged output stream.
// The arbiter side is the slave modport; the traffic source/sink side is the master modport.
interface dircc_stream_arbiter_if #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  import dircc_stream_pkg::*;

  localparam int CH_W = clog2_min1(N_CH);

  logic [N_CH-1:0]         stream_in_valid;
  logic [N_CH*DATA_W-1:0]  stream_in_data;
  logic [N_CH-1:0]         stream_in_startofpacket;
  logic [N_CH-1:0]         stream_in_endofpacket;
  logic [N_CH*EMPTY_W-1:0] stream_in_empty;
  logic [N_CH-1:0]         stream_in_ready;

  logic                    stream_out_valid;
  logic [DATA_W-1:0]       stream_out_data;
  logic                    stream_out_startofpacket;
  logic                    stream_out_endofpacket;
  logic [EMPTY_W-1:0]      stream_out_empty;
  logic [CH_W-1:0]         stream_out_channel;
  logic                    stream_out_ready;

  modport master (
    output stream_in_valid, stream_in_data, stream_in_startofpacket,
           stream_in_endofpacket, stream_in_empty, stream_out_ready,
    input  stream_in_ready, stream_out_valid, stream_out_data,
           stream_out_startofpacket, stream_out_endofpacket,
           stream_out_empty, stream_out_channel
  );

  modport slave (
    input  stream_in_valid, stream_in_data, stream_in_startofpacket,
           stream_in_endofpacket, stream_in_empty, stream_out_ready,
    output stream_in_ready, stream_out_valid, stream_out_data,
           stream_out_startofpacket, stream_out_endofpacket,
           stream_out_empty, stream_out_channel
  );

endinterface

// File: rtl/dircc_stream_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or after i_ptr, searching upward with wrap.
// Returns a one-hot grant, its index and whether any request was present.
module dircc_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic         w_found;
  logic [W-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = W'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/dircc_stream_arbiter.sv
// Packet-atomic round-robin merge of N_CH Avalon-ST streams into one registered, channel-tagged stream.
// Define DIRCC_ARB_STATS_EN to add the saturating stat_pkt_count / stat_drop_count outputs.
module dircc_stream_arbiter
  import dircc_stream_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  dircc_stream_arbiter_if.slave   bus,
  output logic                    error_sticky
`ifdef DIRCC_ARB_STATS_EN
  ,
  output logic [31:0]             stat_pkt_count,
  output logic [15:0]             stat_drop_count
`endif
);

  localparam int CH_W = clog2_min1(N_CH);

  // Beat layout follows the module parameters, so it is declared here rather than in the package.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [CH_W-1:0]    channel;
  } beat_t;

  arb_state_t      r_state;
  logic [CH_W-1:0] r_grant;
  logic [CH_W-1:0] r_rrPtr;
  logic            r_valid;
  beat_t           r_beat;
  logic            r_error;
`ifdef DIRCC_ARB_STATS_EN
  logic [31:0]     r_pktCount;
  logic [15:0]     r_dropCount;
`endif

  logic            w_outFree;
  logic [N_CH-1:0] w_cand;
  logic [N_CH-1:0] w_malformed;
  logic [N_CH-1:0] w_drain;
  logic [N_CH-1:0] w_winOneHot;
  logic [N_CH-1:0] w_ready;
  logic [CH_W-1:0] w_winIdx;
  logic [CH_W-1:0] w_selIdx;
  logic            w_winAny;
  logic            w_load;
  beat_t           w_next;

  assign w_outFree   = ~r_valid | bus.stream_out_ready;
  assign w_cand      = bus.stream_in_valid & bus.stream_in_startofpacket;
  assign w_malformed = bus.stream_in_valid & ~bus.stream_in_startofpacket;

  dircc_rr_picker #(.N(N_CH), .W(CH_W)) u_picker (
    .i_req   (w_cand),
    .i_ptr   (r_rrPtr),
    .o_grant (w_winOneHot),
    .o_idx   (w_winIdx),
    .o_any   (w_winAny)
  );

  // Drained and granted channels are disjoint: candidates carry sop, malformed beats do not.
  always_comb begin
    w_ready  = '0;
    w_drain  = '0;
    w_load   = 1'b0;
    w_selIdx = r_grant;
    if (w_outFree) begin
      if (r_state == IDLE) begin
        w_drain  = w_malformed & (~w_malformed + N_CH'(1));
        w_ready  = w_winOneHot | w_drain;
        w_load   = w_winAny;
        w_selIdx = w_winIdx;
      end else begin
        w_ready[r_grant] = 1'b1;
        w_load           = bus.stream_in_valid[r_grant];
      end
    end
    w_next.data    = bus.stream_in_data[int'(w_selIdx)*DATA_W +: DATA_W];
    w_next.sop     = bus.stream_in_startofpacket[w_selIdx];
    w_next.eop     = bus.stream_in_endofpacket[w_selIdx];
    w_next.empty   = bus.stream_in_empty[int'(w_selIdx)*EMPTY_W +: EMPTY_W];
    w_next.channel = w_selIdx;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rrPtr <= '0;
      r_valid <= 1'b0;
      r_beat  <= '0;
      r_error <= 1'b0;
`ifdef DIRCC_ARB_STATS_EN
      r_pktCount  <= '0;
      r_dropCount <= '0;
`endif
    end else begin
      if (|w_drain) r_error <= 1'b1;
      if (w_load) begin
        r_beat  <= w_next;
        r_valid <= 1'b1;
      end else if (bus.stream_out_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_grant <= w_winIdx;
            r_rrPtr <= (int'(w_winIdx) == N_CH - 1) ? '0 : w_winIdx + CH_W'(1);
            if (!w_next.eop) r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_load && w_next.eop) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef DIRCC_ARB_STATS_EN
      if (r_valid && bus.stream_out_ready && r_beat.eop && (r_pktCount != '1))
        r_pktCount <= r_pktCount + 32'd1;
      if ((|w_drain) && (r_dropCount != '1))
        r_dropCount <= r_dropCount + 16'd1;
`endif
    end
  end

  assign bus.stream_in_ready          = w_ready;
  assign bus.stream_out_valid         = r_valid;
  assign bus.stream_out_data          = r_beat.data;
  assign bus.stream_out_startofpacket = r_beat.sop;
  assign bus.stream_out_endofpacket   = r_beat.eop;
  assign bus.stream_out_empty         = r_beat.empty;
  assign bus.stream_out_channel       = r_beat.channel;
  assign error_sticky                 = r_error;
`ifdef DIRCC_ARB_STATS_EN
  assign stat_pkt_count  = r_pktCount;
  assign stat_drop_count = r_dropCount;
`endif

endmodule

// File: tb/tb_dircc_stream_arbiter.sv
// Directed table-driven bench for dircc_stream_arbiter: per-channel beat sources feed the DUT and a
// per-cycle table of hand-derived expected readies and output beats is compared cycle by cycle.
module tb_dircc_stream_arbiter;

  localparam int N_CH    = 4;
  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;
  localparam int CH_W    = 2;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic errorSticky;
`ifdef DIRCC_ARB_STATS_EN
  logic [31:0] statPkt;
  logic [15:0] statDrop;
`endif

  dircc_stream_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) bus ();

  dircc_stream_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rstN),
    .bus             (bus),
    .error_sticky    (errorSticky)
`ifdef DIRCC_ARB_STATS_EN
    ,
    .stat_pkt_count  (statPkt),
    .stat_drop_count (statDrop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pkt;
    logic [7:0] beat;
    logic       sop;
    logic       eop;
  } srcBeat_t;

  typedef struct {
    logic            outReady;
    logic [N_CH-1:0] expRdy;
    logic            expValid;
    int              expCh;
    int              expPkt;
    int              expBeat;
    logic            expSop;
    logic            expEop;
    logic            expErr;
  } vec_t;

  srcBeat_t srcMem [N_CH][DEPTH];
  int       head [N_CH];
  int       tail [N_CH];
  vec_t     vecs [$];
  int       nCompared   = 0;
  int       nMismatched = 0;

  function automatic logic [DATA_W-1:0] mkData(input int c, input int p, input int b);
    return 32'hC000_0000 | (32'(c) << 16) | (32'(p) << 8) | 32'(b);
  endfunction

  function automatic logic [EMPTY_W-1:0] mkEmpty(input int c, input int b);
    return EMPTY_W'(c + b);
  endfunction

  // Output bundle: {pad, error, valid, sop, eop, empty, channel, data}.
  function automatic logic [63:0] packOut();
    return {24'd0, errorSticky, bus.stream_out_valid, bus.stream_out_startofpacket,
            bus.stream_out_endofpacket, bus.stream_out_empty, bus.stream_out_channel,
            bus.stream_out_data};
  endfunction

  task automatic checkOutput(input string name, input int row, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic clearSrc();
    for (int c = 0; c < N_CH; c++) begin
      head[c] = 0;
      tail[c] = 0;
    end
  endtask

  task automatic loadBeat(input int c, input int p, input int b, input logic sop, input logic eop);
    srcMem[c][tail[c]] = '{pkt: 8'(p), beat: 8'(b), sop: sop, eop: eop};
    tail[c]++;
  endtask

  task automatic addVec(input logic outReady, input logic [N_CH-1:0] rdy, input logic v,
                        input int ch, input int p, input int b, input logic sop,
                        input logic eop, input logic err);
    vec_t t;
    t.outReady = outReady;
    t.expRdy   = rdy;
    t.expValid = v;
    t.expCh    = ch;
    t.expPkt   = p;
    t.expBeat  = b;
    t.expSop   = sop;
    t.expEop   = eop;
    t.expErr   = err;
    vecs.push_back(t);
  endtask

  // Present the head beat of every non-empty source; empty sources drive zeros.
  task automatic applyStimulus();
    srcBeat_t s;
    for (int c = 0; c < N_CH; c++) begin
      if (head[c] < tail[c]) begin
        s = srcMem[c][head[c]];
        bus.stream_in_valid[c]                      = 1'b1;
        bus.stream_in_data[c*DATA_W +: DATA_W]      = mkData(c, int'(s.pkt), int'(s.beat));
        bus.stream_in_startofpacket[c]              = s.sop;
        bus.stream_in_endofpacket[c]                = s.eop;
        bus.stream_in_empty[c*EMPTY_W +: EMPTY_W]   = mkEmpty(c, int'(s.beat));
      end else begin
        bus.stream_in_valid[c]                      = 1'b0;
        bus.stream_in_data[c*DATA_W +: DATA_W]      = '0;
        bus.stream_in_startofpacket[c]              = 1'b0;
        bus.stream_in_endofpacket[c]                = 1'b0;
        bus.stream_in_empty[c*EMPTY_W +: EMPTY_W]   = '0;
      end
    end
  endtask

  task automatic runVecs(input string tag);
    logic [N_CH-1:0] acc;
    logic [63:0]     act;
    logic [63:0]     exp;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.stream_out_ready = vecs[i].outReady;
      applyStimulus();
      @(negedge clk);
      checkOutput({tag, "_rdy"}, i, 64'(bus.stream_in_ready), 64'(vecs[i].expRdy));
      acc = bus.stream_in_ready & bus.stream_in_valid;
      @(posedge clk);
      #1;
      act = packOut();
      if (vecs[i].expValid) begin
        exp = {24'd0, vecs[i].expErr, 1'b1, vecs[i].expSop, vecs[i].expEop,
               mkEmpty(vecs[i].expCh, vecs[i].expBeat), CH_W'(vecs[i].expCh),
               mkData(vecs[i].expCh, vecs[i].expPkt, vecs[i].expBeat)};
      end else begin
        exp = {24'd0, vecs[i].expErr, 1'b0, 38'd0};
        act[37:0] = '0;
      end
      checkOutput({tag, "_out"}, i, act, exp);
      for (int c = 0; c < N_CH; c++) begin
        if (acc[c]) head[c]++;
      end
    end
    vecs.delete();
  endtask

  initial begin
    bus.stream_in_valid         = '0;
    bus.stream_in_data          = '0;
    bus.stream_in_startofpacket = '0;
    bus.stream_in_endofpacket   = '0;
    bus.stream_in_empty         = '0;
    bus.stream_out_ready        = 1'b0;
    clearSrc();

    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("reset_out", 0, packOut(), 64'd0);
    checkOutput("reset_rdy", 0, 64'(bus.stream_in_ready), 64'd0);

    $display("[TB] t1: four simultaneous 3-beat packets");
    clearSrc();
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < 3; b++) loadBeat(c, 0, b, b == 0, b == 2);
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < 3; b++) addVec(1, N_CH'(1 << c), 1, c, 0, b, b == 0, b == 2, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    runVecs("t1");

    $display("[TB] t2: single-beat stream on ch2 against 4-beat packets on ch0");
    clearSrc();
    for (int p = 1; p <= 2; p++)
      for (int b = 0; b < 4; b++) loadBeat(0, p, b, b == 0, b == 3);
    for (int p = 0; p < 3; p++) loadBeat(2, p, 0, 1, 1);
    addVec(1, 4'b0001, 1, 0, 1, 0, 1, 0, 0);
    addVec(1, 4'b0001, 1, 0, 1, 1, 0, 0, 0);
    addVec(1, 4'b0001, 1, 0, 1, 2, 0, 0, 0);
    addVec(1, 4'b0001, 1, 0, 1, 3, 0, 1, 0);
    addVec(1, 4'b0100, 1, 2, 0, 0, 1, 1, 0);
    addVec(1, 4'b0001, 1, 0, 2, 0, 1, 0, 0);
    addVec(1, 4'b0001, 1, 0, 2, 1, 0, 0, 0);
    addVec(1, 4'b0001, 1, 0, 2, 2, 0, 0, 0);
    addVec(1, 4'b0001, 1, 0, 2, 3, 0, 1, 0);
    addVec(1, 4'b0100, 1, 2, 1, 0, 1, 1, 0);
    addVec(1, 4'b0100, 1, 2, 2, 0, 1, 1, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    runVecs("t2");

    $display("[TB] t3: downstream stall mid-packet");
    clearSrc();
    for (int b = 0; b < 4; b++) loadBeat(1, 5, b, b == 0, b == 3);
    loadBeat(2, 7, 0, 1, 1);
    addVec(1, 4'b0010, 1, 1, 5, 0, 1, 0, 0);
    addVec(1, 4'b0010, 1, 1, 5, 1, 0, 0, 0);
    addVec(0, 4'b0000, 1, 1, 5, 1, 0, 0, 0);
    addVec(0, 4'b0000, 1, 1, 5, 1, 0, 0, 0);
    addVec(1, 4'b0010, 1, 1, 5, 2, 0, 0, 0);
    addVec(1, 4'b0010, 1, 1, 5, 3, 0, 1, 0);
    addVec(0, 4'b0000, 1, 1, 5, 3, 0, 1, 0);
    addVec(1, 4'b0100, 1, 2, 7, 0, 1, 1, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    runVecs("t3");

    $display("[TB] t4: malformed beats drained before a proper packet");
    clearSrc();
    loadBeat(1, 9, 0, 0, 0);
    loadBeat(1, 9, 1, 0, 0);
    loadBeat(1, 10, 0, 1, 0);
    loadBeat(1, 10, 1, 0, 1);
    addVec(1, 4'b0010, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 4'b0010, 0, 0, 0, 0, 0, 0, 1);
    addVec(1, 4'b0010, 1, 1, 10, 0, 1, 0, 1);
    addVec(1, 4'b0010, 1, 1, 10, 1, 0, 1, 1);
    addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
    runVecs("t4");
`ifdef DIRCC_ARB_STATS_EN
    checkOutput("t4_stat_pkt", 0, 64'(statPkt), 64'd12);
    checkOutput("t4_stat_drop", 0, 64'(statDrop), 64'd2);
`endif

    $display("[TB] t4b: drain coinciding with a grant on another channel");
    clearSrc();
    loadBeat(3, 12, 0, 1, 1);
    loadBeat(2, 13, 0, 0, 0);
    addVec(1, 4'b1100, 1, 3, 12, 0, 1, 1, 1);
    addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
    runVecs("t4b");
`ifdef DIRCC_ARB_STATS_EN
    checkOutput("t4b_stat_pkt", 0, 64'(statPkt), 64'd13);
    checkOutput("t4b_stat_drop", 0, 64'(statDrop), 64'd3);
`endif

    $display("[TB] t5: reset in the middle of a ch3 packet");
    clearSrc();
    for (int b = 0; b < 4; b++) loadBeat(3, 14, b, b == 0, b == 3);
    addVec(1, 4'b1000, 1, 3, 14, 0, 1, 0, 1);
    addVec(1, 4'b1000, 1, 3, 14, 1, 0, 0, 1);
    runVecs("t5a");
    rstN = 1'b0;
    bus.stream_out_ready = 1'b1;
    applyStimulus();
    @(posedge clk);
    #1;
    rstN = 1'b1;
    checkOutput("t5_reset_out", 0, packOut(), 64'd0);
`ifdef DIRCC_ARB_STATS_EN
    checkOutput("t5_reset_stat_pkt", 0, 64'(statPkt), 64'd0);
    checkOutput("t5_reset_stat_drop", 0, 64'(statDrop), 64'd0);
`endif
    clearSrc();
    loadBeat(3, 15, 0, 1, 1);
    loadBeat(0, 16, 0, 1, 1);
    addVec(1, 4'b0001, 1, 0, 16, 0, 1, 1, 0);
    addVec(1, 4'b1000, 1, 3, 15, 0, 1, 1, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    runVecs("t5b");
`ifdef DIRCC_ARB_STATS_EN
    checkOutput("t5_stat_pkt", 0, 64'(statPkt), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
